// File: rtl/native_out_port_pkg.sv
// Shared types for the native video output port: mode names,
// timing field width, FSM states and the per-axis timing bundle.
package native_out_port_pkg;

  localparam int    TW        = 16;
  localparam string MODE_ONCE = "ONCE";
  localparam string MODE_LINE = "LINE";

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  typedef logic [TW-1:0] fld_t;
  typedef logic [TW:0]   sum_t;

  // One axis of video timing, in sync/porch/active/porch order.
  typedef struct packed {
    fld_t sw;
    fld_t bp;
    fld_t act;
    fld_t fp;
  } axis_t;

  function automatic sum_t axis_total(axis_t a);
    return sum_t'(a.sw) + sum_t'(a.bp)
         + sum_t'(a.act) + sum_t'(a.fp);
  endfunction

endpackage

// File: rtl/native_out_port_if.sv
// Pixel stream in / video timing out bundle of native_out_port.
// master: upstream pixel source + video sink; slave: the port itself.
interface native_out_port_if #(
  parameter int DSIZE = 24
);
  logic [DSIZE-1:0] idata;
  logic             idata_vld;
  logic             idata_rdy;
  logic             falign;
  logic             lalign;
  logic             ealign;
  logic             vsync;
  logic             hsync;
  logic             de;
  logic [DSIZE-1:0] odata;
  logic             underflow;

  modport master (
    output idata, idata_vld,
    input  idata_rdy, falign, lalign, ealign,
    input  vsync, hsync, de, odata, underflow
  );

  modport slave (
    input  idata, idata_vld,
    output idata_rdy, falign, lalign, ealign,
    output vsync, hsync, de, odata, underflow
  );
endinterface

// File: rtl/native_timing_gen.sv
// IDLE/RUN FSM, shadowed timing, h/v counters and window decode.
// Ports: clock, rst, enable, h/v timing in; decoded strobes out.
module native_timing_gen
  import native_out_port_pkg::*;
(
  input  logic  clock,
  input  logic  rst,
  input  logic  enable,
  input  axis_t h,
  input  axis_t v,
  output logic  hs,
  output logic  vs,
  output logic  act,
  output logic  line_end,
  output logic  frame_end,
  output logic  frame_start
);

  state_t state;
  axis_t  hsh, vsh;
  fld_t   hcnt, vcnt;
  sum_t   htot, vtot, hc, vc;
  sum_t   hab, hae, vab, vae;
  logic   run, hlast, vlast;
  logic   hact, vact;

  always_comb begin
    htot  = axis_total(hsh);
    vtot  = axis_total(vsh);
    hc    = sum_t'(hcnt);
    vc    = sum_t'(vcnt);
    hab   = sum_t'(hsh.sw) + sum_t'(hsh.bp);
    hae   = hab + sum_t'(hsh.act);
    vab   = sum_t'(vsh.sw) + sum_t'(vsh.bp);
    vae   = vab + sum_t'(vsh.act);
    run   = (state == ST_RUN);
    hlast = (hc == htot - sum_t'(1));
    vlast = (vc == vtot - sum_t'(1));
    hact  = (hc >= hab) && (hc < hae);
    vact  = (vc >= vab) && (vc < vae);
    hs    = run && (hc < sum_t'(hsh.sw));
    vs    = run && (vc < sum_t'(vsh.sw));
    act   = run && hact && vact;
    line_end    = act && (hc == hae - sum_t'(1));
    frame_end   = line_end
               && (vc == vae - sum_t'(1));
    frame_start = run && (hcnt == '0)
               && (vcnt == '0);
  end

  // Shadows reload only on the frame's last cycle
  // so a frame always runs on one timing set.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      hcnt  <= '0;
      vcnt  <= '0;
      hsh   <= '0;
      vsh   <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (enable) begin
            state <= ST_RUN;
            hsh   <= h;
            vsh   <= v;
          end
        end
        ST_RUN: begin
          if (hlast) begin
            hcnt <= '0;
            if (vlast) begin
              vcnt <= '0;
              hsh  <= h;
              vsh  <= v;
              if (!enable)
                state <= ST_IDLE;
            end else begin
              vcnt <= vcnt + fld_t'(1);
            end
          end else begin
            hcnt <= hcnt + fld_t'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/native_out_port.sv
// Native video output port: pulls pixels on a fixed raster and emits
// registered vsync/hsync/de/odata plus frame/line/end align pulses.
// Ports: clock, rst, enable, h/v timing fields, bus (slave).
module native_out_port
  import native_out_port_pkg::*;
#(
  parameter int    DSIZE = 24,
  parameter string MODE  = MODE_ONCE
)(
  input  logic   clock,
  input  logic   rst,
  input  logic   enable,
  input  fld_t   hactive,
  input  fld_t   hfp,
  input  fld_t   hsw,
  input  fld_t   hbp,
  input  fld_t   vactive,
  input  fld_t   vfp,
  input  fld_t   vsw,
  input  fld_t   vbp,
  native_out_port_if.slave bus
);

  localparam bit LINE_EN = (MODE == MODE_LINE);

  axis_t hax, vax;
  logic  hs, vs, act;
  logic  line_end, frame_end, frame_start;
  logic  lflag, eflag;

  assign hax = '{sw: hsw, bp: hbp,
                 act: hactive, fp: hfp};
  assign vax = '{sw: vsw, bp: vbp,
                 act: vactive, fp: vfp};

  native_timing_gen u_tgen (
    .clock       (clock),
    .rst         (rst),
    .enable      (enable),
    .h           (hax),
    .v           (vax),
    .hs          (hs),
    .vs          (vs),
    .act         (act),
    .line_end    (line_end),
    .frame_end   (frame_end),
    .frame_start (frame_start)
  );

  assign bus.idata_rdy = act;

  // Align pulses go through an extra flag stage so they
  // land one cycle after the last de, not with it.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      bus.de        <= 1'b0;
      bus.hsync     <= 1'b0;
      bus.vsync     <= 1'b0;
      bus.falign    <= 1'b0;
      bus.lalign    <= 1'b0;
      bus.ealign    <= 1'b0;
      bus.underflow <= 1'b0;
      bus.odata     <= '0;
      lflag         <= 1'b0;
      eflag         <= 1'b0;
    end else begin
      bus.de        <= act;
      bus.hsync     <= hs;
      bus.vsync     <= vs;
      bus.falign    <= frame_start;
      bus.underflow <= act && !bus.idata_vld;
      lflag         <= LINE_EN && line_end;
      bus.lalign    <= lflag;
      eflag         <= frame_end;
      bus.ealign    <= eflag;
      if (act)
        bus.odata <= bus.idata_vld ? bus.idata
                                   : {DSIZE{1'b0}};
    end
  end

endmodule

// File: doc/native_out_port.md
NATIVE_OUT_PORT -- requirements
Module: native_out_port

Interface
REQ-001 Parameter DSIZE, default 24, pixel data width.
REQ-002 Parameter MODE, default "ONCE", "ONCE" or "LINE"; selects whether lalign pulses.
REQ-003 clock  input  1  sole clock; all logic on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 enable  input  1  run request, sampled only at frame boundaries.
REQ-006 hactive, hfp, hsw, hbp  input  16 each  horizontal active pixels, front porch, sync width, back porch (cycles).
REQ-007 vactive, vfp, vsw, vbp  input  16 each  vertical active lines, front porch, sync width, back porch (lines).
REQ-008 idata  input  DSIZE  upstream pixel data.
REQ-009 idata_vld  input  1  upstream data valid.
REQ-010 idata_rdy  output  1  pixel consumed this cycle when idata_rdy and idata_vld are both high.
REQ-011 falign  output  1  one-cycle pulse at frame start, for upstream frame realign.
REQ-012 lalign  output  1  one-cycle pulse at end of each active line (MODE "LINE" only).
REQ-013 ealign  output  1  one-cycle pulse after last active pixel of the frame.
REQ-014 vsync, hsync, de  output  1 each  registered video timing, active-high.
REQ-015 odata  output  DSIZE  registered pixel, aligned with de.
REQ-016 underflow  output  1  one-cycle pulse on each active cycle with no valid input.

Function
REQ-017 States IDLE and RUN; IDLE->RUN when enable=1 in IDLE; RUN->IDLE when enable=0 at the last cycle of a frame (hcnt=htotal-1, vcnt=vtotal-1).
REQ-018 htotal = hsw+hbp+hactive+hfp and vtotal = vsw+vbp+vactive+vfp, computed 17-bit; totals >65535 or any active/sync field 0 are unsupported.
REQ-019 hcnt counts 0..htotal-1 and wraps to 0; vcnt increments on hcnt wrap and counts 0..vtotal-1, wrapping to 0; both held at 0 in IDLE.
REQ-020 Line order: sync [0,hsw), back porch, active [hsw+hbp, hsw+hbp+hactive), front porch; same order vertically in lines.
REQ-021 idata_rdy is combinational: high only in RUN when both hcnt and vcnt are in their active windows.
REQ-022 Outputs register one cycle after counter decode: de(t+1)=idata_rdy(t); hsync and vsync are delayed identically.
REQ-023 odata(t+1) = idata(t) if idata_rdy and idata_vld; else 0 while de; else odata holds.
REQ-024 underflow(t+1) = idata_rdy(t) and not idata_vld(t); no stall; the timing never waits for data.
REQ-025 falign pulses in the cycle vsync first rises (registered, aligned with vsync).
REQ-026 lalign, when MODE="LINE", pulses in the cycle after the last de of each active line; constant 0 for "ONCE".
REQ-027 ealign pulses in the cycle after the last de of the last active line; coincides with the last lalign in "LINE" mode.
REQ-028 Timing inputs are sampled into shadow registers at IDLE->RUN and at each frame wrap; mid-frame changes do not affect the current frame.
REQ-029 In IDLE: vsync, hsync, de, idata_rdy, falign, lalign, ealign, underflow all 0.

Reset
REQ-030 rst=1 asynchronously forces IDLE, counters 0, all outputs 0, odata 0, shadow registers 0.
REQ-031 Reset asserted mid-frame aborts the frame immediately; after release, the block restarts from vcnt=0 at the next enable.

Structure
REQ-032 Shared package holds the MODE string constants, the 16-bit timing field width, and state encodings.
REQ-033 One sub-module, native_timing_gen: shadow registers, h/v counters, and window decode; native_out_port adds the handshake, data register and align pulses.

Verification
Use hsw=1,hbp=1,hactive=4,hfp=1 (htotal 7) and vsw=1,vbp=1,vactive=3,vfp=1 (vtotal 6): 42 cycles per frame.
REQ-034 enable=1, idata_vld always 1, idata counting from 0 -> de high 4 cycles per line on lines 2..4; odata 0..11; falign once per 42 cycles; underflow never.
REQ-035 MODE="LINE" -> 3 lalign pulses per frame, each one cycle after the last de of a line; ealign is coincident with the third lalign.
REQ-036 idata_vld=0 on the 2nd active cycle of line 2 -> odata=0 for that de cycle; one underflow pulse; frame timing unchanged.
REQ-037 enable dropped mid-frame -> frame completes all 42 cycles, then IDLE with all outputs 0; re-enable -> falign within 1 cycle of the IDLE->RUN transition.
REQ-038 hactive changed 4->2 mid-frame -> the current frame keeps 4 de per line; the next frame has 2 de per line with htotal 5.
REQ-039 rst pulsed during an active line -> all outputs 0 in the same cycle; the next frame starts cleanly with vcnt=0.
